// File: rtl/calc_sequencer.sv
// Step-button front end for the 4-bit add/sub calculator: loads A0, A1 and the operation,
// lets the datapath settle, latches F/Cout, and drives the per-digit HEX enables.
module calc_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int BLINK_DIV     = 12500000,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [3:0] sw_data,
  input  logic       sw_op,
  input  logic [3:0] F,
  input  logic       Cout,
  output logic [3:0] a0,
  output logic [3:0] a1,
  output logic       s,
  output logic [3:0] result,
  output logic       carry,
  output logic       valid,
  output logic       busy,
  output logic [2:0] state,
  output logic [5:0] digit_en
);

  typedef enum logic [2:0] {
    LOAD_A0 = 3'd0,
    LOAD_A1 = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  state_t           st;
  logic [2:0]       k_sync;
  logic             step;
  logic [SET_W-1:0] settle;
  logic [CNT_W-1:0] bcnt;
  logic             blink;

  // Two synchronizer flops plus one history flop; a held key yields a single falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) k_sync <= 3'b111;
    else       k_sync <= {k_sync[1:0], key_n};
  end

  assign step = k_sync[2] & ~k_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= LOAD_A0;
      a0     <= '0;
      a1     <= '0;
      s      <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      settle <= '0;
    end else begin
      case (st)
        LOAD_A0: if (step) begin
          a0    <= sw_data;
          valid <= 1'b0;
          st    <= LOAD_A1;
        end
        LOAD_A1: if (step) begin
          a1 <= sw_data;
          st <= LOAD_OP;
        end
        LOAD_OP: if (step) begin
          s      <= sw_op;
          settle <= '0;
          busy   <= 1'b1;
          st     <= EXEC;
        end
        EXEC: begin
          settle <= settle + 1'b1;
          if (settle == SET_W'(SETTLE_CYCLES - 1)) begin
            result <= F;
            carry  <= Cout;
            valid  <= 1'b1;
            busy   <= 1'b0;
            st     <= SHOW;
          end
        end
        SHOW: if (step) st <= LOAD_A0;
        default: st <= LOAD_A0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt  <= '0;
      blink <= 1'b1;
    end else if (bcnt == CNT_W'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  assign state = st;

  // HEX5..HEX0 = A0, op, A1, '=', sign, F; the field being edited blinks.
  always_comb begin
    digit_en = 6'b000000;
    case (st)
      LOAD_A0: digit_en = {blink, 5'b00000};
      LOAD_A1: digit_en = {1'b1, 1'b0, blink, 3'b000};
      LOAD_OP: digit_en = {1'b1, blink, 1'b1, 3'b000};
      EXEC:    digit_en = 6'b111000;
      SHOW:    digit_en = 6'b111111;
      default: digit_en = 6'b000000;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboarded bench for calc_sequencer: stimulus pushes expected results,
// a monitor pops them whenever a fresh result becomes valid.
module tb_calc_sequencer;

  localparam int SETTLE = 4;
  localparam int BDIV   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic [3:0] sw_data = 4'h0;
  logic       sw_op = 1'b0;
  logic [3:0] F;
  logic       Cout;
  logic [3:0] a0, a1, result;
  logic       s, carry, valid, busy;
  logic [2:0] state;
  logic [5:0] digit_en;

  calc_sequencer #(.SETTLE_CYCLES(SETTLE), .BLINK_DIV(BDIV), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw_data(sw_data), .sw_op(sw_op),
    .F(F), .Cout(Cout), .a0(a0), .a1(a1), .s(s), .result(result), .carry(carry),
    .valid(valid), .busy(busy), .state(state), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  // Datapath model: subtract reports a borrow in Cout.
  always_comb begin
    if (s) begin
      F    = a0 - a1;
      Cout = (a0 < a1);
    end else begin
      {Cout, F} = {1'b0, a0} + {1'b0, a1};
    end
  end

  typedef struct {
    logic [3:0] r;
    logic       c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc;

  always @(posedge clk or posedge reset) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_blink();
    return ((ncyc / BDIV) % 2) == 0;
  endfunction

  function automatic logic [5:0] exp_den(input int st);
    logic b;
    b = exp_blink();
    case (st)
      0: return {b, 5'b00000};
      1: return {1'b1, 1'b0, b, 3'b000};
      2: return {1'b1, b, 1'b1, 3'b000};
      3: return 6'b111000;
      default: return 6'b111111;
    endcase
  endfunction

  // Monitor: on each fresh result, pop the expectation and check it.
  logic valid_q = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      valid_q  = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (valid && !valid_q) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got %0h expected none", result);
        end else begin
          e = q.pop_front();
          chk("result", result, e.r);
          chk("carry", carry, e.c);
          chk("busy_cycles", busy_cnt, SETTLE);
          chk("show_state", state, 4);
          chk("show_digits", digit_en, 6'h3f);
        end
        busy_cnt = 0;
      end
      valid_q = valid;
    end
  end

  // Called at a negedge; checks the 3-clock step latency and that holding gives one step.
  task automatic press_exact(input int st_before, input int st_after, input int hold);
    key_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("step_latency", state, st_before);
    @(negedge clk);
    chk("step_state", state, st_after);
    chk("step_digits", digit_en, exp_den(st_after));
    repeat (hold) @(negedge clk);
    chk("held_key", state, st_after);
    key_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_state(input int st, input string nm);
    int n = 0;
    while (state !== st && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, state, st);
  endtask

  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic op, input int blink_n);
    exp_t e;
    int   sum;
    sw_data = a;
    press_exact(0, 1, $urandom_range(0, 6));
    chk("a0_load", a0, a);
    chk("valid_clr", valid, 0);
    sw_data = 4'($urandom);
    for (int i = 0; i < blink_n; i++) begin
      @(negedge clk);
      chk("blink_a1", digit_en, exp_den(1));
    end
    sw_data = b;
    press_exact(1, 2, $urandom_range(0, 6));
    chk("a1_load", a1, b);
    chk("a0_hold", a0, a);
    if (op) begin
      sum = int'(a) - int'(b);
      e.r = 4'(sum);
      e.c = (a < b);
    end else begin
      sum = int'(a) + int'(b);
      e.r = 4'(sum);
      e.c = (sum > 15);
    end
    q.push_back(e);
    sw_op = op;
    key_n = 1'b0;
    wait_state(3, "enter_exec");
    chk("exec_busy", busy, 1);
    chk("exec_digits", digit_en, exp_den(3));
  endtask

  task automatic do_seq(input logic [3:0] a, input logic [3:0] b, input logic op,
                        input bit exec_press, input int blink_n);
    logic [3:0] er;
    er = op ? 4'(a - b) : 4'(a + b);
    start_op(a, b, op, blink_n);
    if (exec_press) begin
      key_n = 1'b1;
      @(negedge clk);
      key_n = 1'b0;
    end
    wait_state(4, "reach_show");
    key_n = 1'b1;
    sw_op = ~op;
    repeat (6) @(negedge clk);
    chk("show_hold", state, 4);
    chk("s_hold", s, op);
    chk("show_a0", a0, a);
    chk("show_a1", a1, b);
    chk("show_result", result, er);
    chk("show_valid", valid, 1);
    sw_data = 4'($urandom);
    press_exact(4, 0, $urandom_range(0, 6));
    chk("valid_keep", valid, 1);
    chk("result_keep", result, er);
    chk("a0_keep", a0, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_a0", a0, 0);
    chk("rst_a1", a1, 0);
    chk("rst_s", s, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_digits", digit_en, 6'b100000);
    reset = 1'b0;
    @(negedge clk);

    sw_data = 4'h5;
    press_exact(0, 1, 10);
    chk("first_a0", a0, 4'h5);
    chk("first_valid", valid, 0);
    // Finish this partial sequence through a full operation.
    sw_data = 4'h1;
    press_exact(1, 2, 0);
    q.push_back('{r: 4'h6, c: 1'b0});
    sw_op = 1'b0;
    key_n = 1'b0;
    wait_state(4, "first_show");
    key_n = 1'b1;
    repeat (4) @(negedge clk);
    press_exact(4, 0, 2);

    do_seq(4'h7, 4'h3, 1'b0, 1'b0, 12);
    do_seq(4'h2, 4'h5, 1'b1, 1'b0, 0);
    do_seq(4'hF, 4'h1, 1'b0, 1'b1, 0);
    do_seq(4'h3, 4'h3, 1'b1, 1'b1, 5);

    // Abort mid-EXEC with an asynchronous reset.
    start_op(4'h9, 4'h6, 1'b0, 0);
    key_n = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_state", state, 0);
    chk("abort_a0", a0, 0);
    chk("abort_a1", a1, 0);
    chk("abort_s", s, 0);
    chk("abort_result", result, 0);
    chk("abort_carry", carry, 0);
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    void'(q.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("abort_digits", digit_en, 6'b100000);
    repeat (3) @(negedge clk);
    chk("abort_no_result", valid, 0);

    for (int i = 0; i < 8; i++)
      do_seq(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 6));

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
